// File: rtl/nim_pkg.sv
// Shared types and constants for the multi-pile Nim bank.
// Optional build macro: NIM_ZERO_REROLL_EN (skip zero draws during a fill).
package nim_pkg;

  localparam int NIM_MAX_PILES = 16;
  localparam int NIM_DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } pile_state_t;

endpackage : nim_pkg

// File: rtl/rise_detect.sv
// Rising-edge detector for the debounced load button.
// Only the 0->1 transition of the level input produces a one-cycle rise.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic rise
);

  logic load_q;
  logic load_d;

  always_comb begin
    load_d = load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q <= 1'b0;
    end else begin
      load_q <= load_d;
    end
  end

  assign rise = load & ~load_q;

endmodule : rise_detect

// File: rtl/nim_pile_bank.sv
// Bank of PILES Nim pile counters: filled one pile per cycle from a random
// source on a load edge, then drained by validated take requests.
// Optional build macro: NIM_ZERO_REROLL_EN (zero draws are skipped during a fill).
module nim_pile_bank
  import nim_pkg::*;
#(
  parameter int WIDTH = NIM_DEF_WIDTH,
  parameter int PILES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [WIDTH-1:0]         random,
  input  logic [$clog2(PILES)-1:0] sel,
  input  logic [WIDTH-1:0]         take,
  input  logic                     take_valid,
  output logic [PILES*WIDTH-1:0]   piles,
  output logic                     busy,
  output logic                     fill_done,
  output logic                     take_ok,
  output logic                     take_err,
  output logic                     all_empty
);

  localparam int IDX_W = $clog2(PILES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PILES - 1);

  pile_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] pile_q [PILES];
  logic [WIDTH-1:0] pile_d [PILES];
  logic             busy_q, busy_d;
  logic             fill_done_q, fill_done_d;
  logic             take_ok_q, take_ok_d;
  logic             take_err_q, take_err_d;

  logic             rise;
  logic             fill_write;
  logic             last_idx;
  logic             sel_in_range;
  logic [WIDTH-1:0] pile_sel;
  logic             take_accept;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .rise  (rise)
  );

`ifdef NIM_ZERO_REROLL_EN
  // A zero draw is discarded so every pile starts non-empty.
  assign fill_write = (random != '0);
`else
  assign fill_write = 1'b1;
`endif

  assign last_idx     = (idx_q == LAST_IDX);
  assign sel_in_range = (int'(sel) < PILES);
  assign pile_sel     = sel_in_range ? pile_q[sel] : '0;
  // A simultaneous load edge always wins over a take.
  assign take_accept  = sel_in_range && (take != '0) && (take <= pile_sel) && !rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = FILL;
      FILL:    if (fill_write && last_idx) state_d = READY;
      READY:   if (rise) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    fill_done_d = 1'b0;
    take_ok_d   = 1'b0;
    take_err_d  = 1'b0;
    for (int i = 0; i < PILES; i++) begin
      pile_d[i] = pile_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (rise) idx_d = '0;
        if (take_valid) take_err_d = 1'b1;
      end
      FILL: begin
        if (take_valid) take_err_d = 1'b1;
        if (fill_write) begin
          pile_d[idx_q] = random;
          idx_d         = last_idx ? '0 : idx_q + 1'b1;
          fill_done_d   = last_idx;
        end
      end
      READY: begin
        if (rise) idx_d = '0;
        if (take_valid) begin
          if (take_accept) begin
            pile_d[sel] = pile_q[sel] - take;
            take_ok_d   = 1'b1;
          end else begin
            take_err_d  = 1'b1;
          end
        end
      end
      default: begin
        idx_d = '0;
      end
    endcase

    busy_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      busy_q      <= 1'b0;
      fill_done_q <= 1'b0;
      take_ok_q   <= 1'b0;
      take_err_q  <= 1'b0;
      for (int i = 0; i < PILES; i++) begin
        pile_q[i] <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      fill_done_q <= fill_done_d;
      take_ok_q   <= take_ok_d;
      take_err_q  <= take_err_d;
      for (int i = 0; i < PILES; i++) begin
        pile_q[i] <= pile_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PILES; i++) begin
      piles[i*WIDTH +: WIDTH] = pile_q[i];
    end
  end

  assign all_empty = (piles == '0);
  assign busy      = busy_q;
  assign fill_done = fill_done_q;
  assign take_ok   = take_ok_q;
  assign take_err  = take_err_q;

endmodule : nim_pile_bank

// File: doc/nim_pile_bank.md
# nim_pile_bank

- Parametrised multi-pile successor to the single-value capture register.
- Holds `PILES` independent pile counts of `WIDTH` bits each.
- On a rising edge of `load`, fills the piles one per cycle from the free-running `random` source.
- Applies validated player "take" requests that subtract from one selected pile, and flags when every pile is empty (end of game).

## Interface
Parameters:
- `WIDTH`, 4: bits per pile count.
- `PILES`, 4: number of piles; legal range 2..16.

Ports:
- `clk` input 1: single system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. Asserting it (0) clears all state immediately; deassertion is synchronous to `clk` by the upstream reset synchroniser.
- `load` input 1: level request from the debounced button. Only its 0→1 transition is acted on.
- `random` input WIDTH: free-running pseudo-random value, new value each cycle.
- `sel` input $clog2(PILES): pile index for a take.
- `take` input WIDTH: amount to remove.
- `take_valid` input 1: single-cycle take request strobe.
- `piles` output PILES*WIDTH: pile contents, pile i at bits [i*WIDTH +: WIDTH].
- `busy` output 1: high while filling.
- `fill_done` output 1: one-cycle pulse when the last pile has been written.
- `take_ok` output 1: one-cycle pulse when a take was applied.
- `take_err` output 1: one-cycle pulse when a take was rejected.
- `all_empty` output 1: combinational; high when every pile is 0.

## Operation
States:
- IDLE: after reset.
- FILL: writing piles.
- READY: game in progress.

Load edge detection:
- `load_q` <= `load` every cycle.
- `rise` = `load` & ~`load_q`.

Transitions:
- IDLE or READY with `rise` → FILL, `idx` <= 0. Pile contents are unchanged on this edge.
- FILL: each cycle `pile[idx]` <= `random` and `idx` increments. When `idx` == PILES-1 on that write: → READY and `fill_done` pulses.

Take request (`take_valid`=1), evaluated in READY:
- Accepted iff `sel` < PILES, `take` != 0, `take` <= `pile[sel]`, and `rise`=0.
- On accept: `pile[sel]` <= `pile[sel]` - `take` and `take_ok`=1.
- On reject: `take_err`=1 and piles unchanged.
- Subtraction is unsigned WIDTH-bit and cannot underflow, because of the accept check.

Take request in IDLE or FILL: always `take_err`=1; no state change.

Simultaneous events:
- `rise` together with `take_valid` in READY: the load wins, the take is rejected (`take_err`), and the FSM goes to FILL.
- `rise` during FILL is ignored; the fill is not restarted.

Mid-fill reset: all piles return to 0 and the FSM returns to IDLE; a partial fill is never visible after reset.

## Timing
- Reset values: `piles`=0, `busy`=0, `fill_done`=0, `take_ok`=0, `take_err`=0, `all_empty`=1, `load_q`=0, `idx`=0, state IDLE.
- Fill latency: the first clock edge sampling `load`=1 (with `load_q`=0) enters FILL. The next PILES edges write piles 0..PILES-1. `fill_done` and READY are visible after edge PILES+1.
- `busy` is registered and equals (state == FILL).
- Take latency: one edge. The pile update and the `take_ok`/`take_err` pulse are visible together after the edge that sampled `take_valid`.
- `take_ok` and `take_err` are never high in the same cycle.
- `all_empty` follows the `piles` register with no added latency.

## Configuration
- `NIM_ZERO_REROLL_EN` defined: in FILL, a `random` value of 0 is not written and `idx` does not advance. The fill therefore takes PILES or more cycles, and every pile is non-zero at `fill_done`.
- Not defined: zero values are written as-is, and the fill always takes exactly PILES cycles.

## Structure
Package `nim_pkg` holds:
- State enum `pile_state_t` (IDLE, FILL, READY).
- Constants `NIM_MAX_PILES`=16 and `NIM_DEF_WIDTH`=4.

Sub-module: one natural sub-module, `rise_detect`, containing the `load_q` register and `rise` output, with the same clock/reset as the top.

## Test plan
- Reset then `load` 0→1 with `random` sequence 3,5,7,2 (PILES=4) → `busy` high for 4 cycles; `piles`={2,7,5,3} (pile 3 down to pile 0); `fill_done` pulses once; `all_empty`=0.
- READY with pile1=5: take 5 from sel=1 → `take_ok`, pile1=0. Then take 1 from sel=1 → `take_err`, pile1 stays 0.
- Take 0, take 9 from a pile of 7, and `take_valid` during FILL → each gives `take_err` with piles unchanged.
- Empty all piles with valid takes → `all_empty` rises in the same cycle the last pile reaches 0.
- `load` held high across the fill, plus a second rising edge during FILL → exactly one fill. `rise` with `take_valid` in READY → take rejected, new fill starts.
- Reset asserted mid-fill → outputs at reset values asynchronously. With `NIM_ZERO_REROLL_EN`, `random` 0,4,0,0,1,6,8 → `piles`={8,6,1,4}.
